// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide engine.
// One bit per cycle: radix-2 shift-add multiply and restoring divide.
// Divide-by-zero and signed-overflow divides finish in a single cycle.
// The sign fix is applied on the edge that enters DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0]   ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO2   = {(2*XLEN){1'b0}};
  localparam logic [2*XLEN-1:0] ONE2    = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [1:0]        sel_r;       // func3[1:0] of the op in flight
  logic              neg_r;       // negate product / quotient at the end
  logic              neg_rem_r;   // remainder takes the dividend's sign
  logic [2*XLEN-1:0] prod_r;
  logic [2*XLEN-1:0] mcand_r;     // multiplicand magnitude, shifted left per step
  logic [XLEN-1:0]   shreg_r;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [XLEN-1:0]   dvs_r;       // divisor magnitude
  logic [XLEN-1:0]   prem_r;      // restored partial remainder, always below the divisor

  logic              sgn_a_s, sgn_b_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, spec_res_s;
  logic              div_zero_s, div_ovf_s;

  logic [2*XLEN-1:0] prod_nxt_s, prod_fin_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN:0]     rem_sh_s, diff_s;
  logic              q_bit_s;
  logic [XLEN-1:0]   rem_nxt_s, quo_nxt_s, quo_fin_s, rem_fin_s, div_res_s;

  // Decode signedness, operand magnitudes and the single-cycle special cases
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    if (func3[2]) begin
      sgn_a_s = ~func3[0];
      sgn_b_s = ~func3[0];
    end else begin
      sgn_a_s = (func3[1:0] == 2'b01) || (func3[1:0] == 2'b10);
      sgn_b_s = (func3[1:0] == 2'b01);
    end
    a_neg_s    = sgn_a_s & op_a[XLEN-1];
    b_neg_s    = sgn_b_s & op_b[XLEN-1];
    a_mag_s    = a_neg_s ? (~op_a + ONE) : op_a;
    b_mag_s    = b_neg_s ? (~op_b + ONE) : op_b;
    div_zero_s = func3[2] & (op_b == ZERO);
    div_ovf_s  = func3[2] & ~func3[0] & (op_a == MIN_NEG) & (op_b == ONES);
    if (div_zero_s) begin
      spec_res_s = func3[1] ? op_a : ONES;
    end else if (div_ovf_s) begin
      spec_res_s = func3[1] ? ZERO : op_a;
    end else begin
      spec_res_s = ZERO;
    end
  end

  // One multiply step, one restoring-divide step, and the final sign fix
  always_comb begin
    prod_nxt_s = prod_r + (shreg_r[0] ? mcand_r : ZERO2);
    prod_fin_s = neg_r ? (~prod_nxt_s + ONE2) : prod_nxt_s;
    mul_res_s  = (sel_r == 2'b00) ? prod_fin_s[XLEN-1:0] : prod_fin_s[2*XLEN-1:XLEN];
    rem_sh_s   = {prem_r, shreg_r[XLEN-1]};
    diff_s     = rem_sh_s - {1'b0, dvs_r};
    q_bit_s    = ~diff_s[XLEN];
    rem_nxt_s  = q_bit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
    quo_nxt_s  = {shreg_r[XLEN-2:0], q_bit_s};
    quo_fin_s  = neg_r ? (~quo_nxt_s + ONE) : quo_nxt_s;
    rem_fin_s  = neg_rem_r ? (~rem_nxt_s + ONE) : rem_nxt_s;
    div_res_s  = sel_r[1] ? rem_fin_s : quo_fin_s;
  end

  // Control FSM with the iteration datapath and registered busy/done/result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= ZERO;
      cnt_r     <= {CW{1'b0}};
      sel_r     <= 2'b00;
      neg_r     <= 1'b0;
      neg_rem_r <= 1'b0;
      prod_r    <= ZERO2;
      mcand_r   <= ZERO2;
      shreg_r   <= ZERO;
      dvs_r     <= ZERO;
      prem_r    <= ZERO;
    end else if (flush) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            sel_r     <= func3[1:0];
            neg_r     <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            cnt_r     <= CW'(XLEN-1);
            prod_r    <= ZERO2;
            prem_r    <= ZERO;
            mcand_r   <= {ZERO, a_mag_s};
            shreg_r   <= func3[2] ? a_mag_s : b_mag_s;
            dvs_r     <= b_mag_s;
            if (div_zero_s | div_ovf_s) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              result  <= spec_res_s;
            end else begin
              state_r <= func3[2] ? S_DIV : S_MUL;
              busy    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_r  <= prod_nxt_s;
          mcand_r <= mcand_r << 1;
          shreg_r <= shreg_r >> 1;
          cnt_r   <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= mul_res_s;
          end
        end
        S_DIV: begin
          prem_r  <= rem_nxt_s;
          shreg_r <= quo_nxt_s;
          cnt_r   <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= div_res_s;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
